// File: rtl/fetch_unit.sv
// fetch_unit: PC stream, pipelined InstMem requests, prefetch FIFO to decode; accept -> instValid in 2 cycles, 1 inst/cycle.
// Stalls on romReady/instReady under a DEPTH credit cap; define FETCH_ALIGN_CHK_EN for sticky addrErr on misaligned redirect.
module fetch_unit #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] PC_START = '0,
  parameter int unsigned     PC_STEP  = 4,
  parameter int unsigned     DEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jCe,
  input  logic [PC_W-1:0]   jAddr,
  output logic              romReq,
  output logic [PC_W-1:0]   romAddr,
  input  logic              romReady,
  input  logic              romValid,
  input  logic [INST_W-1:0] romData,
  output logic              instValid,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   instPc,
  input  logic              instReady
`ifdef FETCH_ALIGN_CHK_EN
  ,
  output logic              addrErr
`endif
);
  localparam int unsigned     AW   = $clog2(DEPTH);
  localparam int unsigned     CW   = AW + 1;
  localparam logic [PC_W-1:0] STEP = PC_W'(PC_STEP);
  localparam logic [CW:0]     CAP  = (CW+1)'(DEPTH);

  logic              rst_q;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [PC_W-1:0]   out_pc_q, out_pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [INST_W-1:0] mem_q [DEPTH];
  logic              halt;
  logic              accept;
  logic              push;
  logic              pop;
  logic [CW:0]       used;

`ifdef FETCH_ALIGN_CHK_EN
  logic err_q, err_d;
  assign halt    = err_q;
  assign addrErr = err_q;
`else
  assign halt = 1'b0;
`endif

  // In-flight plus buffered words may never exceed DEPTH, so a push always finds space.
  assign used      = {1'b0, outst_q} + {1'b0, cnt_q};
  assign romReq    = !rst && !rst_q && !jCe && !halt && (used < CAP);
  assign romAddr   = pc_q;
  assign accept    = romReq && romReady;
  assign push      = romValid && !jCe && (drop_q == '0);
  assign instValid = (cnt_q != '0);
  assign pop       = instValid && instReady && !jCe;
  assign inst      = mem_q[rd_q];
  assign instPc    = out_pc_q;

  always_comb begin
    pc_d     = pc_q;
    out_pc_d = out_pc_q;
    outst_d  = outst_q;
    drop_d   = drop_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
`ifdef FETCH_ALIGN_CHK_EN
    err_d    = err_q;
`endif
    if (accept && !romValid) begin
      outst_d = outst_q + CW'(1);
    end else if (!accept && romValid) begin
      outst_d = outst_q - CW'(1);
    end
    if (jCe) begin
      pc_d     = jAddr;
      out_pc_d = jAddr;
      // No request goes out in a redirect cycle, so everything still in flight is stale.
      drop_d   = outst_d;
      cnt_d    = '0;
      rd_d     = wr_q;
`ifdef FETCH_ALIGN_CHK_EN
      err_d    = (jAddr[1:0] != 2'b00);
`endif
    end else begin
      if (accept) begin
        pc_d = pc_q + STEP;
      end
      if (romValid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      if (pop) begin
        rd_d     = rd_q + AW'(1);
        out_pc_d = out_pc_q + STEP;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      pc_q     <= PC_START;
      out_pc_q <= PC_START;
      outst_q  <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
`ifdef FETCH_ALIGN_CHK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      pc_q     <= pc_d;
      out_pc_q <= out_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
`ifdef FETCH_ALIGN_CHK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= romData;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect sequences, then random traffic against a queue model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, jCe, romReq, romReady, romValid, instValid, instReady;
  logic [31:0] jAddr, romAddr, romData, inst, instPc;
`ifdef FETCH_ALIGN_CHK_EN
  logic        addrErr;
`endif

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W(32), .INST_W(32), .PC_START(32'h0), .PC_STEP(4), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .jCe(jCe), .jAddr(jAddr),
    .romReq(romReq), .romAddr(romAddr), .romReady(romReady),
    .romValid(romValid), .romData(romData),
    .instValid(instValid), .inst(inst), .instPc(instPc),
    .instReady(instReady)
`ifdef FETCH_ALIGN_CHK_EN
    ,
    .addrErr(addrErr)
`endif
  );

  typedef struct { logic [31:0] exp_pc; logic [31:0] act_addr; logic stale; int due; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } word_t;
  typedef struct { logic rst; logic ir; logic req; logic [31:0] addr; logic vld; logic [31:0] pc; } vec_t;

  req_t        mq[$];      // accepted requests not yet answered (memory + model)
  word_t       bq[$];      // words the decode stage should see, in order
  logic [31:0] m_pc;
  logic        m_prev_rst;
  logic        m_halt;
  int          cyc, lat, hold_pct;
  bit          hash_en, chk_en;
  int          n_tests, n_fail;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return hash_en ? (a ^ 32'h9E37_79B9) : a;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic drive_mem();
    romValid = 1'b0;
    romData  = '0;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc && $urandom_range(99) >= hold_pct) begin
      romValid = 1'b1;
      romData  = word_of(mq[0].act_addr);
    end
  endtask

  // Reference: requests allowed while in-flight + buffered < DEPTH; words reach decode in PC order.
  task automatic model_step();
    logic exp_req, exp_vld;
    req_t r;
    exp_req = !rst && !m_prev_rst && !jCe && !m_halt && (mq.size() + bq.size() < DEPTH);
    exp_vld = (bq.size() != 0);
    if (chk_en) begin
      check("romReq", romReq, exp_req);
      if (exp_req && romReq) check("romAddr", romAddr, m_pc);
      check("instValid", instValid, exp_vld);
      if (exp_vld && instValid) begin
        check("instPc", instPc, bq[0].pc);
        check("inst", inst, bq[0].data);
      end
`ifdef FETCH_ALIGN_CHK_EN
      check("addrErr", addrErr, m_halt);
`endif
    end
    if (rst) begin
      mq.delete();
      bq.delete();
      m_pc       = 32'h0;
      m_halt     = 1'b0;
      m_prev_rst = 1'b1;
    end else begin
      m_prev_rst = 1'b0;
      if (exp_vld && instReady && !jCe) void'(bq.pop_front());
      if (romValid) begin
        r = mq.pop_front();
        if (!jCe && !r.stale) bq.push_back('{r.exp_pc, word_of(r.exp_pc)});
      end
      if (jCe) begin
        bq.delete();
        for (int i = 0; i < mq.size(); i++) mq[i].stale = 1'b1;
        m_pc = jAddr;
`ifdef FETCH_ALIGN_CHK_EN
        m_halt = (jAddr[1:0] != 2'b00);
`endif
      end else if (romReq && romReady) begin
        mq.push_back('{m_pc, romAddr, 1'b0, cyc + lat});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic cyc_begin();
    drive_mem();
    @(negedge clk);
  endtask

  task automatic cyc_end();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick();
    cyc_begin();
    cyc_end();
  endtask

  vec_t        tbl[16];
  logic [31:0] got[$];
  bit          found;

  initial begin
    rst = 1'b1; jCe = 1'b0; jAddr = '0; romReady = 1'b1; instReady = 1'b0;
    romValid = 1'b0; romData = '0;
    lat = 1; hold_pct = 0; hash_en = 1'b0; chk_en = 1'b0;
    m_pc = '0; m_prev_rst = 1'b1; m_halt = 1'b0; cyc = 0;
    n_tests = 0; n_fail = 0;

    // rst, instReady, romReq, romAddr, instValid, instPc  (1-cycle memory, word = address)
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h00};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h00};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h04};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    tbl[14] = '{1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    tbl[15] = '{1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};

    for (int i = 0; i < 16; i++) begin
      rst = tbl[i].rst;
      instReady = tbl[i].ir;
      cyc_begin();
      check($sformatf("vec%0d.romReq", i), romReq, tbl[i].req);
      if (tbl[i].req) check($sformatf("vec%0d.romAddr", i), romAddr, tbl[i].addr);
      check($sformatf("vec%0d.instValid", i), instValid, tbl[i].vld);
      if (tbl[i].vld) begin
        check($sformatf("vec%0d.instPc", i), instPc, tbl[i].pc);
        check($sformatf("vec%0d.inst", i), inst, tbl[i].pc);
      end
      cyc_end();
    end

    // Redirect in a cycle that also pops and receives a response.
    chk_en = 1'b1;
    jCe = 1'b1; jAddr = 32'h300;
    cyc_begin();
    check("rpr.busy_vld", instValid, 1'b1);
    cyc_end();
    jCe = 1'b0;
    cyc_begin();
    check("rpr.flushed", instValid, 1'b0);
    check("rpr.req", romReq, 1'b1);
    check("rpr.addr", romAddr, 32'h300);
    cyc_end();
    cyc_begin();
    check("rpr.empty2", instValid, 1'b0);
    cyc_end();
    cyc_begin();
    check("rpr.vld", instValid, 1'b1);
    check("rpr.pc", instPc, 32'h300);
    check("rpr.inst", inst, 32'h300);
    cyc_end();

    // Redirect with 2 in flight and 1 buffered, 2-cycle memory.
    lat = 2; instReady = 1'b0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (mq.size() == 2 && bq.size() == 1) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL redir.setup cyc=%0d got=no 2-inflight/1-buffered state expected=reached", cyc);
    end
    jCe = 1'b1; jAddr = 32'h100;
    cyc_begin();
    check("redir.noreq", romReq, 1'b0);
    cyc_end();
    jCe = 1'b0; instReady = 1'b1;
    got.delete();
    for (int k = 0; k < 20 && got.size() < 2; k++) begin
      cyc_begin();
      if (instValid) got.push_back(instPc);
      cyc_end();
    end
    n_tests++;
    if (got.size() < 2) begin
      n_fail++;
      $display("FAIL redir.timeout cyc=%0d got=%0d words expected=2", cyc, got.size());
    end else begin
      check("redir.pc0", got[0], 32'h100);
      check("redir.pc1", got[1], 32'h104);
    end

`ifdef FETCH_ALIGN_CHK_EN
    lat = 1;
    jCe = 1'b1; jAddr = 32'h102;
    tick();
    jCe = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc_begin();
      check("align.err", addrErr, 1'b1);
      check("align.noreq", romReq, 1'b0);
      cyc_end();
    end
    jCe = 1'b1; jAddr = 32'h200;
    tick();
    jCe = 1'b0;
    cyc_begin();
    check("align.clr", addrErr, 1'b0);
    check("align.req", romReq, 1'b1);
    check("align.addr", romAddr, 32'h200);
    cyc_end();
`endif

    // Random traffic against the model.
    hash_en = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      rst       = ($urandom_range(499) == 0);
      jCe       = !rst && ($urandom_range(99) < 4);
      jAddr     = $urandom & 32'hFFFF_FFFC;
`ifdef FETCH_ALIGN_CHK_EN
      if ($urandom_range(9) == 0) jAddr[1:0] = 2'($urandom_range(1, 3));
`endif
      romReady  = ($urandom_range(99) < 75);
      instReady = ($urandom_range(99) < 70);
      lat       = 1 + $urandom_range(2);
      hold_pct  = $urandom_range(30);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
